// File: rtl/sr_ctrl_pkg.sv
// rtl/sr_ctrl_pkg.sv - shared types, button levels and width helper for the SR button conditioner
// Contents:
//   sr_state_e   - arbiter FSM states (IDLE, PULSE_S, PULSE_R, GAP)
//   BTN_PRESSED  - raw/debounced level of a pressed (active-low) button
//   BTN_RELEASED - raw/debounced level of a released button
//   cnt_width()  - bit width of a counter that must hold the value n
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } sr_state_e;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

  // One extra bit over clog2 so the terminal value itself is representable.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchroniser, debounce counter and press-edge detector for one button
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   btn_raw in  raw active-low button, asynchronous to clk
//   press   out one-cycle pulse when the debounced level goes released -> pressed
module button_debouncer
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // Any sample agreeing with the stable level leaves cnt_d at zero, so
    // only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = (sync2_q == BTN_PRESSED);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= BTN_RELEASED;
      sync2_q  <= BTN_RELEASED;
      stable_q <= BTN_RELEASED;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// rtl/sr_button_conditioner.sv - turns two bouncing buttons into clean, exclusive S/R latch pulses
// Ports:
//   CLK      in  system clock, rising edge
//   RSTn     in  asynchronous active-low reset
//   BTN_S    in  raw SET button, active-low, asynchronous
//   BTN_R    in  raw RESET button, active-low, asynchronous
//   S        out registered SET pulse, PULSE_CYCLES wide
//   R        out registered RESET pulse, PULSE_CYCLES wide
//   CONFLICT out one-cycle flag: simultaneous SET and RESET requests discarded
//   BUSY     out high while the FSM is not IDLE
module sr_button_conditioner
  import sr_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic BTN_S,
  input  logic BTN_R,
  output logic S,
  output logic R,
  output logic CONFLICT,
  output logic BUSY
);

  localparam int            PW       = cnt_width(PULSE_CYCLES);
  localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE_CYCLES);
  localparam logic [PW-1:0] PCNT_ONE = PW'(1);

  sr_state_e     state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          pend_s_q, pend_s_d;
  logic          pend_r_q, pend_r_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          conflict_q, conflict_d;
  logic          busy_q, busy_d;
  logic          press_s, press_r;
  logic          req_s, req_r;
  logic          take_conflict;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_s (
    .clk    (CLK),
    .rst_n  (RSTn),
    .btn_raw(BTN_S),
    .press  (press_s)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_r (
    .clk    (CLK),
    .rst_n  (RSTn),
    .btn_raw(BTN_R),
    .press  (press_r)
  );

  // State, pending and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      busy_q     <= busy_d;
    end
  end

  // Next state. A press arriving this cycle counts as a request at once, so
  // an idle FSM reacts on the very next edge without a pending-bit round trip.
  // The edge leaving GAP already arbitrates as IDLE would; that keeps the
  // start-to-start spacing of back-to-back pulses at PULSE_CYCLES+1.
  always_comb begin
    req_s         = pend_s_q | press_s;
    req_r         = pend_r_q | press_r;
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    pend_s_d      = req_s;
    pend_r_d      = req_r;
    take_conflict = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (req_s && req_r) begin
          pend_s_d      = 1'b0;
          pend_r_d      = 1'b0;
          take_conflict = 1'b1;
        end else if (req_s) begin
          state_d  = PULSE_S;
          pend_s_d = 1'b0;
          pcnt_d   = PCNT_ONE;
        end else if (req_r) begin
          state_d  = PULSE_R;
          pend_r_d = 1'b0;
          pcnt_d   = PCNT_ONE;
        end
      end
      PULSE_S, PULSE_R: begin
        // pcnt counts pulse cycles already driven; it stops at PCNT_MAX.
        if (pcnt_q >= PCNT_MAX) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so S/R are
  // glitch-free and can only be high while the FSM sits in a pulse state.
  always_comb begin
    s_d        = (state_d == PULSE_S);
    r_d        = (state_d == PULSE_R);
    busy_d     = (state_d != IDLE);
    conflict_d = take_conflict;
  end

  assign S        = s_q;
  assign R        = r_q;
  assign CONFLICT = conflict_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// tb/tb_sr_button_conditioner.sv - self-checking bench for sr_button_conditioner
module tb_sr_button_conditioner;

  localparam int D    = 4;
  localparam int P    = 2;
  localparam int MAXE = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_s = 1'b0;
  logic btn_r = 1'b0;
  logic s_o, r_o, conflict_o, busy_o;

  int checks = 0;
  int errors = 0;

  sr_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P)
  ) dut (
    .CLK     (clk),
    .RSTn    (rst_n),
    .BTN_S   (btn_s),
    .BTN_R   (btn_r),
    .S       (s_o),
    .R       (r_o),
    .CONFLICT(conflict_o),
    .BUSY    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: raw sample history per button, time-stamped pulses.
  bit hs [MAXE];
  bit hr [MAXE];
  int m_e, m_next, m_start, m_kind;
  bit m_stab_s, m_stab_r, m_pend_s, m_pend_r;
  bit m_s, m_r, m_conf, m_busy;

  task automatic model_reset();
    m_e = 0; m_next = 0; m_start = -100; m_kind = 0;
    m_stab_s = 1'b1; m_stab_r = 1'b1; m_pend_s = 1'b0; m_pend_r = 1'b0;
    m_s = 1'b0; m_r = 1'b0; m_conf = 1'b0; m_busy = 1'b0;
  endtask

  // The debounced level flips at edge e when the D synchronised samples seen
  // at edges e-D+1..e (raw values taken two edges earlier) all differ from it.
  function automatic bit settles(input bit which_r, input int e, input bit stab);
    int idx;
    bit v;
    for (int j = 0; j < D; j++) begin
      idx = e - 2 - j;
      if (idx < 0) v = 1'b1;
      else v = which_r ? hr[idx] : hs[idx];
      if (v == stab) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit bs, input bit br);
    if (m_e >= MAXE) begin
      $display("FAIL model_history_overflow got %0d expected below %0d", m_e, MAXE);
      errors++;
      $fatal(1, "history overflow");
    end
    hs[m_e] = bs;
    hr[m_e] = br;
    m_conf = 1'b0;
    if (m_e >= m_next) begin
      if (m_pend_s && m_pend_r) begin
        m_conf = 1'b1; m_pend_s = 1'b0; m_pend_r = 1'b0;
      end else if (m_pend_s) begin
        m_kind = 1; m_start = m_e; m_pend_s = 1'b0; m_next = m_e + P + 1;
      end else if (m_pend_r) begin
        m_kind = 2; m_start = m_e; m_pend_r = 1'b0; m_next = m_e + P + 1;
      end
    end
    if (settles(1'b0, m_e, m_stab_s)) begin
      m_stab_s = !m_stab_s;
      if (!m_stab_s) m_pend_s = 1'b1;
    end
    if (settles(1'b1, m_e, m_stab_r)) begin
      m_stab_r = !m_stab_r;
      if (!m_stab_r) m_pend_r = 1'b1;
    end
    m_s    = (m_kind == 1) && (m_e - m_start < P);
    m_r    = (m_kind == 2) && (m_e - m_start < P);
    m_busy = (m_kind != 0) && (m_e - m_start <= P);
    m_e++;
  endtask

  initial model_reset();

  // Compare process: every edge, step the model and check all outputs.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(btn_s, btn_r);
    #1;
    chk("cyc_S", s_o, m_s);
    chk("cyc_R", r_o, m_r);
    chk("cyc_CONFLICT", conflict_o, m_conf);
    chk("cyc_BUSY", busy_o, m_busy);
    chk("cyc_S_and_R", s_o & r_o, 1'b0);
  end

  // Records outputs over edges 0..n-1; buttons fall before edge s_at / r_at.
  task automatic run_rec(input int n, input int s_at, input int r_at,
                         output logic [31:0] vs, output logic [31:0] vr,
                         output logic [31:0] vc, output logic [31:0] vb);
    vs = '0; vr = '0; vc = '0; vb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == s_at) btn_s = 1'b0;
      if (i == r_at) btn_r = 1'b0;
      @(posedge clk);
      #1;
      vs[i] = s_o; vr[i] = r_o; vc[i] = conflict_o; vb[i] = busy_o;
    end
  endtask

  task automatic release_wait();
    @(negedge clk);
    btn_s = 1'b1;
    btn_r = 1'b1;
    repeat (14) @(posedge clk);
    #1;
  endtask

  logic [31:0] vs, vr, vc, vb;
  logic        any_hi;
  int          cnt_s, cnt_r;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with both buttons pressed.
    rst_n = 1'b0; btn_s = 1'b0; btn_r = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_outputs", {s_o, r_o, conflict_o, busy_o}, 4'b0000);
    @(negedge clk);
    btn_s = 1'b1; btn_r = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    any_hi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      any_hi = any_hi | s_o | r_o | conflict_o | busy_o;
    end
    chk("post_reset_quiet", any_hi, 1'b0);

    // Clean SET press.
    run_rec(12, 0, -1, vs, vr, vc, vb);
    chk("clean_S", vs, 32'h0C0);
    chk("clean_BUSY", vb, 32'h1C0);
    chk("clean_R", vr, 32'h0);
    chk("clean_CONFLICT", vc, 32'h0);
    release_wait();

    // Bounce: toggles every 2 cycles for 20 cycles, then held low.
    any_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btn_s = ((i / 2) % 2 == 1);
      @(posedge clk);
      #1;
      any_hi = any_hi | s_o | busy_o;
    end
    chk("bounce_no_pulse", any_hi, 1'b0);
    run_rec(14, 0, -1, vs, vr, vc, vb);
    chk("bounce_S", vs, 32'h0C0);
    release_wait();

    // Simultaneous press.
    run_rec(12, 0, 0, vs, vr, vc, vb);
    chk("simul_S", vs, 32'h0);
    chk("simul_R", vr, 32'h0);
    chk("simul_CONFLICT", vc, 32'h040);
    chk("simul_BUSY", vb, 32'h0);
    release_wait();

    // Queued request: R event lands during PULSE_S.
    run_rec(14, 0, 1, vs, vr, vc, vb);
    chk("queue_S", vs, 32'h0C0);
    chk("queue_R", vr, 32'h600);
    chk("queue_BUSY", vb, 32'hFC0);
    chk("queue_excl", vs & vr, 32'h0);
    release_wait();

    // Async reset mid-pulse with an R request pending.
    @(negedge clk); btn_s = 1'b0;
    @(negedge clk); btn_r = 1'b0;
    for (int i = 0; i < 20 && !s_o; i++) begin
      @(posedge clk);
      #1;
    end
    chk("async_S_seen", s_o, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_S_drop", s_o, 1'b0);
    chk("async_BUSY_drop", busy_o, 1'b0);
    btn_s = 1'b1; btn_r = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    any_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      any_hi = any_hi | s_o | r_o | busy_o;
    end
    chk("async_no_pending", any_hi, 1'b0);

    // Randomised bouncing on both buttons, with the odd reset.
    cnt_s = 0; cnt_r = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (cnt_s == 0) begin
        btn_s = $urandom_range(0, 1) != 0;
        cnt_s = $urandom_range(1, 9);
      end else cnt_s--;
      if (cnt_r == 0) begin
        btn_r = $urandom_range(0, 1) != 0;
        cnt_r = $urandom_range(1, 9);
      end else cnt_r--;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_button_conditioner.md
# sr_button_conditioner

Upstream driver for the gated NOR SR latch: turns two raw, bouncing push-buttons (SET, RESET) into clean, synchronous, mutually exclusive S/R pulses. Each button is synchronised, debounced and edge-detected; an arbiter/FSM emits a fixed-width pulse on S or R, never both, with a guaranteed idle gap between pulses. S and R connect directly to the latch's S/R inputs, and both blocks share CLK.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a new button level (≥2)
- PULSE_CYCLES, 1, width of each S/R output pulse in CLK cycles (≥1)
- CLK  in  1  system clock, all logic on rising edge
- RSTn  in  1  asynchronous, active-low reset
- BTN_S  in  1  raw SET button, active-low, asynchronous to CLK
- BTN_R  in  1  raw RESET button, active-low, asynchronous to CLK
- S  out  1  SET pulse to latch, active-high, registered
- R  out  1  RESET pulse to latch, active-high, registered
- CONFLICT  out  1  one-cycle flag: simultaneous SET and RESET requests were discarded
- BUSY  out  1  high whenever the FSM is not IDLE

## Operation
- Per button: 2-flop synchroniser -> debouncer -> press-edge detector. Debounced level resets to "released".
- Debouncer: counter clears while the synchronised level equals the stable level; it increments while the levels differ. After DEBOUNCE_CYCLES consecutive differing samples, the stable level flips and the counter clears. Any agreeing sample before that clears the counter (bounce rejected).
- Press event: the stable level goes released->pressed. Release events are ignored.
- Press events set a pending bit (pend_s / pend_r). The bit clears when the FSM accepts it or when the request is discarded as a conflict.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE, only pend_s set -> PULSE_S, clear pend_s.
  - IDLE, only pend_r set -> PULSE_R, clear pend_r.
  - IDLE, both set -> stay IDLE, clear both, CONFLICT=1 for one cycle.
  - PULSE_S/PULSE_R: S or R held high for PULSE_CYCLES cycles, then -> GAP.
  - GAP: one cycle with S=R=0, then -> IDLE.
- Press events arriving during PULSE_x or GAP are latched as pending and served on return to IDLE, with the same conflict rule.
- Invariants: S&R never high together; S/R are only asserted from PULSE states.

## Timing
- Reset (RSTn=0, asynchronous): S=0, R=0, CONFLICT=0, BUSY=0; FSM in IDLE; pending bits, counters and synchronisers cleared; stable levels = released. Reset mid-pulse drops S/R immediately.
- Latency: a button level first sampled at edge k becomes stable at edge k+1+DEBOUNCE_CYCLES. S or R is high after edge k+2+DEBOUNCE_CYCLES, provided the FSM was IDLE.
- A pulse occupies PULSE_CYCLES cycles plus 1 GAP cycle. Minimum spacing between consecutive pulses is PULSE_CYCLES+1 cycles.
- CONFLICT rises on the edge at which IDLE would otherwise have entered a pulse state.
- BUSY is high from the edge entering PULSE_x through the GAP cycle.
- Widths: counter width is clog2(DEBOUNCE_CYCLES)+1. The pulse counter is clog2(PULSE_CYCLES)+1 and saturates; no wrap-around is possible.

## Structure
- Package sr_ctrl_pkg: FSM state typedef (IDLE, PULSE_S, PULSE_R, GAP), button level constants BTN_PRESSED=1'b0 and BTN_RELEASED=1'b1, and a width helper function.
- Sub-module button_debouncer (synchroniser, debounce counter and press-edge output), instantiated twice. The arbiter/FSM lives in the top.

## Test plan
All tests use DEBOUNCE_CYCLES=4 and PULSE_CYCLES=2.
- Reset: hold RSTn=0 with both buttons pressed -> S=R=CONFLICT=BUSY=0. Release reset with buttons released -> outputs stay 0.
- Clean SET press: BTN_S falls, first sampled at edge 0 -> S=1 after edges 6 and 7, S=0 after edge 8 (GAP), BUSY=0 after edge 9; R stays 0.
- Bounce: BTN_S toggles low/high every 2 cycles for 20 cycles, then is held low -> no S pulse during toggling; exactly one S pulse, 6 edges after the final stable low is first sampled.
- Simultaneous: BTN_S and BTN_R fall on the same cycle -> S=R=0 throughout; CONFLICT=1 for exactly one cycle at edge 6.
- Queued request: BTN_R pressed so that its event lands during PULSE_S -> R pulse begins the cycle after GAP; S and R are never high together.
- Async reset mid-pulse: RSTn=0 while S=1 -> S=0 immediately without a clock edge. After release, BUSY=0 and no pending pulse is emitted.
